// File: rtl/timer_pkg.sv
// Shared mode encodings and helpers for the timer bank.
// Imported by the channel and the top level.
package timer_pkg;

  localparam logic [1:0] MODE_ONE_UP = 2'b00;
  localparam logic [1:0] MODE_ONE_DN = 2'b01;
  localparam logic [1:0] MODE_PER_DN = 2'b10;
  localparam logic [1:0] MODE_PER_UP = 2'b11;

  function automatic logic mode_is_up(input logic [1:0] m);
    return (m == MODE_ONE_UP) || (m == MODE_PER_UP);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: count, reload, mode, sticky done and expire pulse.
// Advances only when the shared tick qualifies it via adv.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             load,
  input  logic             clr,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] preset,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             expire
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] reload_q;
  logic [1:0]       mode_q;
  logic             done_q;
  logic             exp_q;
  logic             fin_q;

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_dec;
  logic             fin_d;
  logic             fire;

  assign cnt_inc = cnt_q + 1'b1;
  assign cnt_dec = cnt_q - 1'b1;

  // fin_q remembers that a one-shot already fired, so a
  // reload of 0 fires once rather than on every advance.
  always_comb begin
    cnt_d = cnt_q;
    fin_d = fin_q;
    fire  = 1'b0;
    unique case (mode_q)
      MODE_ONE_UP: begin
        if (cnt_q == reload_q) begin
          fire  = !fin_q;
          fin_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          fire  = (cnt_inc == reload_q);
          fin_d = fin_q | fire;
        end
      end
      MODE_ONE_DN: begin
        if (cnt_q == '0) begin
          fire  = !fin_q;
          fin_d = 1'b1;
        end else begin
          cnt_d = cnt_dec;
          fire  = (cnt_dec == '0);
          fin_d = fin_q | fire;
        end
      end
      MODE_PER_DN: begin
        if (cnt_q == '0) begin
          cnt_d = reload_q;
          fire  = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      MODE_PER_UP: begin
        if (cnt_q == reload_q) begin
          cnt_d = '0;
          fire  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      reload_q <= '0;
      mode_q   <= MODE_ONE_UP;
      done_q   <= 1'b0;
      exp_q    <= 1'b0;
      fin_q    <= 1'b0;
    end else if (load) begin
      cnt_q    <= mode_is_up(mode_in) ? '0 : preset;
      reload_q <= preset;
      mode_q   <= mode_in;
      done_q   <= 1'b0;
      exp_q    <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      if (adv) begin
        cnt_q <= cnt_d;
        fin_q <= fin_d;
      end
      exp_q <= adv & fire;
      // A terminal event outranks a clear in the same cycle.
      if (adv & fire) begin
        done_q <= 1'b1;
      end else if (clr) begin
        done_q <= 1'b0;
      end
    end
  end

  assign count  = cnt_q;
  assign done   = done_q;
  assign expire = exp_q;

endmodule

// File: rtl/timer_bank.sv
// N-channel timer bank sharing one prescaler tick.
// Combines masked done flags into a registered irq.
module timer_bank
  import timer_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gen_en,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic [N_CH-1:0]       enable,
  input  logic [N_CH-1:0]       load,
  input  logic [N_CH-1:0]       clr,
  input  logic [N_CH-1:0]       irq_en,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [WIDTH*N_CH-1:0] preset,
  output logic [WIDTH*N_CH-1:0] count,
  output logic [N_CH-1:0]       done,
  output logic [N_CH-1:0]       expire,
  output logic                  irq
);

  logic [PRESC_W-1:0] presc_cnt;
  logic               tick;
  logic               irq_q;

  // >= rather than == so a shrinking prescale ticks at once
  // instead of letting the counter run to wrap-around.
  assign tick = gen_en && (presc_cnt >= prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else if (gen_en) begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .adv    (tick & enable[i]),
      .load   (load[i]),
      .clr    (clr[i]),
      .mode_in(mode[2*i +: 2]),
      .preset (preset[WIDTH*i +: WIDTH]),
      .count  (count[WIDTH*i +: WIDTH]),
      .done   (done[i]),
      .expire (expire[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(done & irq_en);
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_timer_bank.sv
// Randomized bench for timer_bank against a cycle-level reference model.
// Directed scenarios first, then random traffic.
module tb_timer_bank;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int PW = 8;
  localparam int MX = (1 << W);

  logic           clk = 1'b0;
  logic           reset;
  logic           gen_en;
  logic [PW-1:0]  prescale;
  logic [N-1:0]   enable;
  logic [N-1:0]   load;
  logic [N-1:0]   clr;
  logic [N-1:0]   irq_en;
  logic [2*N-1:0] mode;
  logic [W*N-1:0] preset;
  logic [W*N-1:0] count;
  logic [N-1:0]   done;
  logic [N-1:0]   expire;
  logic           irq;

  timer_bank #(.N_CH(N), .WIDTH(W), .PRESC_W(PW)) dut (
    .clk     (clk),
    .reset   (reset),
    .gen_en  (gen_en),
    .prescale(prescale),
    .enable  (enable),
    .load    (load),
    .clr     (clr),
    .irq_en  (irq_en),
    .mode    (mode),
    .preset  (preset),
    .count   (count),
    .done    (done),
    .expire  (expire),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int m_pc;
  int m_cnt[N];
  int m_rel[N];
  int m_md[N];
  bit m_done[N];
  bit m_exp[N];
  bit m_fin[N];
  bit m_irq;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Next state of the model from the rules, using inputs as applied.
  task automatic model_edge();
    bit tk, irq_n, up, per, ev;
    int tgt, start, stp;
    if (reset) begin
      m_pc  = 0;
      m_irq = 0;
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0; m_rel[i] = 0; m_md[i] = 0;
        m_done[i] = 0; m_exp[i] = 0; m_fin[i] = 0;
      end
      return;
    end
    tk = gen_en && (m_pc >= int'(prescale));
    irq_n = 0;
    for (int i = 0; i < N; i++) irq_n |= m_done[i] && irq_en[i];
    if (gen_en) m_pc = tk ? 0 : m_pc + 1;
    for (int i = 0; i < N; i++) begin
      ev = 0;
      if (load[i]) begin
        m_md[i]   = int'(mode[2*i +: 2]);
        m_rel[i]  = int'(preset[W*i +: W]);
        up        = (m_md[i] == 0) || (m_md[i] == 3);
        m_cnt[i]  = up ? 0 : m_rel[i];
        m_done[i] = 0; m_exp[i] = 0; m_fin[i] = 0;
      end else begin
        if (tk && enable[i]) begin
          up    = (m_md[i] == 0) || (m_md[i] == 3);
          per   = (m_md[i] >= 2);
          tgt   = up ? m_rel[i] : 0;
          start = up ? 0 : m_rel[i];
          stp   = up ? 1 : MX - 1;
          if (m_cnt[i] == tgt) begin
            if (per) begin
              m_cnt[i] = start;
              ev = 1;
            end else begin
              ev = !m_fin[i];
              m_fin[i] = 1;
            end
          end else begin
            m_cnt[i] = (m_cnt[i] + stp) % MX;
            if (!per && m_cnt[i] == tgt) begin
              ev = 1;
              m_fin[i] = 1;
            end
          end
        end
        m_exp[i] = ev;
        if (ev) m_done[i] = 1;
        else if (clr[i]) m_done[i] = 0;
      end
    end
    m_irq = irq_n;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("count%0d", i), 32'(count[W*i +: W]), 32'(m_cnt[i]));
      check($sformatf("done%0d", i), 32'(done[i]), 32'(m_done[i]));
      check($sformatf("expire%0d", i), 32'(expire[i]), 32'(m_exp[i]));
    end
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic do_load(input int ch, input logic [1:0] md,
                         input logic [W-1:0] pv);
    load[ch]            = 1'b1;
    mode[2*ch +: 2]     = md;
    preset[W*ch +: W]   = pv;
    enable[ch]          = 1'b1;
    cycle();
    load[ch]            = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    gen_en   = 1'b1;
    prescale = 8'd3;
    enable   = '0;
    load     = '0;
    clr      = '0;
    irq_en   = '0;
    mode     = '0;
    preset   = '0;
    cycle();
    cycle();
    reset = 1'b0;

    // Slow tick, then reset mid-run.
    do_load(0, 2'b11, 8'd255);
    repeat (13) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    enable = '0;

    // One-shot down from 5 at full rate.
    prescale = 8'd0;
    do_load(0, 2'b01, 8'd5);
    repeat (9) cycle();

    // Periodic down with a clear between expiries.
    do_load(1, 2'b10, 8'd2);
    repeat (4) cycle();
    clr[1] = 1'b1;
    cycle();
    clr[1] = 1'b0;
    repeat (4) cycle();

    // Periodic up across the full range.
    do_load(2, 2'b11, 8'd255);
    repeat (260) cycle();

    // Clear held through a terminal event.
    do_load(3, 2'b11, 8'd3);
    clr[3] = 1'b1;
    repeat (8) cycle();
    clr[3] = 1'b0;

    // Load landing on a terminal event.
    for (int k = 0; k < 8 && count[W*3 +: W] != 8'd3; k++) cycle();
    check("ld_wait", 32'(count[W*3 +: W]), 32'd3);
    do_load(3, 2'b10, 8'd7);
    repeat (3) cycle();

    // Masked irq.
    irq_en = 4'b0010;
    repeat (10) cycle();
    do_load(0, 2'b01, 8'd1);
    repeat (4) cycle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 299) == 0);
      gen_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) prescale = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) prescale = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) irq_en = 4'($urandom);
      if ($urandom_range(0, 7) == 0) enable = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        load[i] = ($urandom_range(0, 24) == 0);
        clr[i]  = ($urandom_range(0, 7) == 0);
        mode[2*i +: 2] = 2'($urandom);
        preset[W*i +: W] = ($urandom_range(0, 3) == 0) ?
                           8'($urandom) : 8'($urandom_range(0, 4));
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
